// File: rtl/viterbi_puncture.sv
// rtl/viterbi_puncture.sv - puncture and repack the encoder dibit stream into 2-bit words
module viterbi_puncture #(
  parameter int                      p_speed_size = 3,
  parameter logic [p_speed_size-1:0] p_speed_pol0 = 3'b101,
  parameter logic [p_speed_size-1:0] p_speed_pol1 = 3'b011
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  input  logic       i_enable,
  output logic       o_ready,
  output logic [1:0] o_data,
  output logic       o_valid,
  output logic       o_half,
  output logic       o_last
);

  localparam logic [7:0] pol0_ext = 8'(p_speed_pol0);
  localparam logic [7:0] pol1_ext = 8'(p_speed_pol1);
  localparam logic [7:0] full_m   = 8'((9'd1 << p_speed_size) - 9'd1);
  localparam logic [2:0] last_ph  = 3'(p_speed_size - 1);

  generate
    if (p_speed_size < 1 || p_speed_size > 8 || ((pol0_ext | pol1_ext) & full_m) != full_m) begin : g_bad_cfg
      $error("viterbi_puncture: every puncture column must keep at least one bit");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t     state_q, state_d;
  logic       mode_q, mode_d;
  logic [2:0] phase_q, phase_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] buf_q, buf_d;
  logic [1:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       half_q, half_d;
  logic       last_q, last_d;

  logic       accept;
  logic       eff_mode;
  logic       keep0, keep1;
  logic [3:0] merged;
  logic [1:0] pos;
  logic [2:0] total;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    data_d   = 2'b00;
    valid_d  = 1'b0;
    half_d   = 1'b0;
    last_d   = 1'b0;

    accept   = i_valid && (state_q != FLUSH);
    // The first dibit of a frame uses i_enable directly since mode is not latched yet.
    eff_mode = (state_q == IDLE) ? i_enable : mode_q;
    keep0    = !eff_mode || pol0_ext[phase_q];
    keep1    = !eff_mode || pol1_ext[phase_q];

    merged = {1'b0, buf_q};
    pos    = cnt_q;
    if (keep0) begin
      merged[pos] = i_data[0];
      pos         = pos + 2'd1;
    end
    if (keep1) begin
      merged[pos] = i_data[1];
    end
    total = 3'(cnt_q) + 3'(keep0) + 3'(keep1);

    case (state_q)
      FLUSH: begin
        data_d  = {1'b0, buf_q[0]};
        valid_d = 1'b1;
        half_d  = 1'b1;
        last_d  = 1'b1;
        cnt_d   = 2'd0;
        buf_d   = 3'd0;
        phase_d = 3'd0;
        state_d = IDLE;
      end
      default: begin
        if (accept) begin
          if (state_q == IDLE) mode_d = i_enable;
          if (total >= 3'd2) begin
            data_d  = merged[1:0];
            valid_d = 1'b1;
            buf_d   = {1'b0, merged[3:2]};
            cnt_d   = 2'(total - 3'd2);
          end else begin
            buf_d = merged[2:0];
            cnt_d = total[1:0];
          end
          if (i_last) begin
            phase_d = 3'd0;
            // Zero residual means this dibit just emitted the closing word.
            if (cnt_d == 2'd0) begin
              last_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = FLUSH;
            end
          end else begin
            phase_d = (phase_q == last_ph) ? 3'd0 : phase_q + 3'd1;
            state_d = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      phase_q <= 3'd0;
      cnt_q   <= 2'd0;
      buf_q   <= 3'd0;
      data_q  <= 2'b00;
      valid_q <= 1'b0;
      half_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      half_q  <= half_d;
      last_q  <= last_d;
    end
  end

  assign o_ready = (state_q != FLUSH);
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_half  = half_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_viterbi_puncture.sv
// tb/tb_viterbi_puncture.sv - directed bench for viterbi_puncture
module tb_viterbi_puncture;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic [1:0] i_data = 2'b00;
  logic       i_valid = 1'b0;
  logic       i_last = 1'b0;
  logic       i_enable = 1'b0;
  logic       o_ready;
  logic [1:0] o_data;
  logic       o_valid;
  logic       o_half;
  logic       o_last;

  int checks = 0;
  int failures = 0;

  viterbi_puncture dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_enable(i_enable),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_half  (o_half),
    .o_last  (o_last)
  );

  always #5 i_clk = ~i_clk;

  // Expected vector layout: {ready, last, half, valid, data[1:0]}
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {o_ready, o_last, o_half, o_valid, o_data};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] d, input logic l, input logic en);
    @(negedge i_clk);
    i_valid  = v;
    i_data   = d;
    i_last   = l;
    i_enable = en;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    bit         q[$];
    logic [1:0] d;
    logic [1:0] w;
    logic       lst;
    int         ph;
    int         wc;

    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    chk("reset_state", 6'b100000);
    @(negedge i_clk);
    i_reset = 1'b1;

    // Punctured period
    cyc(1, 2'b01, 0, 1); chk("punc_d1", 6'b100101);
    cyc(1, 2'b10, 0, 1); chk("punc_d2", 6'b100000);
    cyc(1, 2'b00, 1, 1); chk("punc_d3", 6'b110101);

    // Odd residual with a dibit held during FLUSH
    cyc(1, 2'b11, 0, 1); chk("odd_d1", 6'b100111);
    cyc(1, 2'b10, 1, 1); chk("odd_flush", 6'b000000);
    cyc(1, 2'b01, 0, 1); chk("odd_half", 6'b111101);

    // Bypass; a captured dropped dibit would shift these words
    cyc(1, 2'b10, 0, 0); chk("byp_d1", 6'b100110);
    cyc(1, 2'b01, 0, 0); chk("byp_d2", 6'b100101);
    cyc(1, 2'b11, 1, 0); chk("byp_d3", 6'b110111);
    cyc(0, 2'b00, 0, 0); chk("byp_idle", 6'b100000);

    // Back-to-back: A punctured, B bypass with i_enable toggled mid-frame
    cyc(1, 2'b11, 0, 1); chk("b2b_a1", 6'b100111);
    cyc(1, 2'b10, 0, 1); chk("b2b_a2", 6'b100000);
    cyc(1, 2'b00, 1, 1); chk("b2b_a3", 6'b110101);
    cyc(1, 2'b10, 0, 0); chk("b2b_b1", 6'b100110);
    cyc(1, 2'b01, 1, 1); chk("b2b_b2", 6'b110101);
    // One-dibit punctured frame
    cyc(1, 2'b10, 1, 1); chk("one_dibit", 6'b110110);

    // Long stream against a bit-queue model
    ph = 0;
    wc = 0;
    for (int i = 0; i < 12; i++) begin
      d = 2'($urandom_range(0, 3));
      cyc(1, d, (i == 11), 1);
      if (ph != 1) q.push_back(d[0]);
      if (ph != 2) q.push_back(d[1]);
      ph = (ph == 2) ? 0 : ph + 1;
      if (o_valid) wc++;
      if (q.size() >= 2) begin
        w[0] = q.pop_front();
        w[1] = q.pop_front();
        lst  = (i == 11) && (q.size() == 0);
        chk($sformatf("long_%0d", i), {1'b1, lst, 1'b0, 1'b1, w});
      end else begin
        chk($sformatf("long_%0d", i), 6'b100000);
      end
    end
    checks++;
    assert (wc === 8) else begin
      failures++;
      $error("FAIL long_count observed=%0d expected=8", wc);
    end

    // Reset mid-frame with a residual bit pending
    cyc(1, 2'b11, 0, 1); chk("rst_d1", 6'b100111);
    cyc(1, 2'b11, 0, 1); chk("rst_d2", 6'b100000);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_reset = 1'b0;
    #1;
    chk("rst_async", 6'b100000);
    @(negedge i_clk);
    i_reset = 1'b1;
    cyc(1, 2'b01, 0, 1); chk("rerun_d1", 6'b100101);
    cyc(1, 2'b10, 0, 1); chk("rerun_d2", 6'b100000);
    cyc(1, 2'b00, 1, 1); chk("rerun_d3", 6'b110101);
    cyc(0, 2'b00, 0, 1); chk("rerun_idle", 6'b100000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/viterbi_puncture.md
# viterbi_puncture

Rate-matching stage placed directly downstream of `viterbi_enc`. It takes the encoder's rate-1/2 dibit stream and deletes bits according to a per-column puncture pattern. The surviving bits are repacked into dense 2-bit output words. It is the transmit-side counterpart of `viterbi_speed_map`, which re-inserts erasures ahead of `viterbi_dec`.

## Interface
Parameters:
- `p_speed_size`, 3: puncture period in input dibits, from 1 to 8.
- `p_speed_pol0`, 3'b101: keep mask for `i_data[0]` (polynomial-0 bit). Bit k applies at phase k.
- `p_speed_pol1`, 3'b011: keep mask for `i_data[1]` (polynomial-1 bit).
- Elaboration fails unless `(p_speed_pol0 | p_speed_pol1)` is all-ones over `p_speed_size` bits, i.e. every column keeps at least one bit.

Ports:
- `i_clk`, in, 1: clock; all logic on the rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_data`, in, 2: encoder dibit. Bit 0 is transmitted before bit 1.
- `i_valid`, in, 1: `i_data` is valid. Accepted only when `o_ready`=1.
- `i_last`, in, 1: qualifies the final dibit of a frame; meaningful only with an accepted `i_valid`.
- `i_enable`, in, 1: 1 = puncture, 0 = bypass (rate 1/2). Sampled on the first accepted dibit of each frame.
- `o_ready`, out, 1: the block accepts input this cycle.
- `o_data`, out, 2: packed output word. Bit 0 is the older bit.
- `o_valid`, out, 1: `o_data` is valid. One-cycle pulse per word.
- `o_half`, out, 1: only `o_data[0]` is meaningful; `o_data[1]` is 0.
- `o_last`, out, 1: the final word of the frame.

## Operation
- **States:** IDLE, RUN, FLUSH.
  - IDLE→RUN on an accepted dibit without `i_last`. This transition latches `i_enable` into `mode`.
  - RUN→IDLE on an accepted `i_last` when the residual count is 0. RUN→FLUSH when the residual count is 1.
  - FLUSH→IDLE unconditionally after one cycle.
  - A first dibit that carries `i_last` is treated as a one-dibit frame: it goes directly to IDLE or FLUSH.
- **`o_ready`:** 1 in IDLE and RUN, 0 in FLUSH. While `o_ready`=0, `i_valid` is ignored and the data is not captured.
- **Phase counter:** 0..`p_speed_size-1`, advances on each accepted dibit and wraps to 0. It resets to 0 after `i_last` and on IDLE entry.
- **Kept bits per accepted dibit:** `d0` if `mode`=0 or `pol0[phase]`=1, then `d1` if `mode`=0 or `pol1[phase]`=1. Order is d0 then d1.
- **Packing:** kept bits are appended to a 3-bit buffer with a count of 0..3.
  - When count+kept ≥ 2, the two oldest bits are emitted, oldest in `o_data[0]`, and count decreases by 2.
  - The count never exceeds 3, so no overflow is possible.
- **Frame end:**
  - If the final dibit leaves count 0, the word it produced carries `o_last`.
  - If it leaves count 1, the FLUSH cycle emits the residual bit as `o_data`={0,bit} with `o_half`=1 and `o_last`=1.
  - The count clears in both cases.
- **Reset:** asserted at any time, including mid-frame or in FLUSH, the block immediately returns to IDLE.
  - phase=0, count=0, buffer=0.
  - Any residual bit is discarded and no `o_last` is produced.

## Timing
- **Reset values:** `o_data`=0, `o_valid`=0, `o_half`=0, `o_last`=0, `o_ready`=1.
- **Latency:** registered outputs. A word produced by a dibit accepted at edge N is visible after edge N, i.e. 1 cycle.
- **FLUSH word:** visible after the edge that ends the FLUSH cycle, i.e. 2 cycles after the last dibit.
- **Throughput:** one dibit per cycle, with at most one word out per cycle. In bypass mode every accepted dibit yields exactly one word.
- **Back-to-back frames:** a new frame may start in the cycle immediately after `i_last` whenever `o_ready`=1.
  - FLUSH costs exactly one bubble.
  - `o_last` and the next frame's first word are never on the same cycle.
- `o_valid`, `o_half` and `o_last` are 0 in every cycle without a word.

## Test plan
- **Punctured period:** defaults, `i_enable`=1, dibits 2'b01, 2'b10, 2'b00 (last on the third).
  - Required: words 2'b01 after the 1st dibit, none after the 2nd, 2'b01 with `o_last` after the 3rd.
  - `o_half`=0 throughout and `o_ready` stays 1.
- **Odd residual:** dibits 2'b11, 2'b10 (last on the second).
  - Required: 2'b11, then nothing, then 2'b01 with `o_half`=1 and `o_last`=1.
  - `o_ready`=0 for exactly the FLUSH cycle; an `i_valid` held during that cycle is dropped.
- **Bypass:** `i_enable`=0, dibits 2'b10, 2'b01, 2'b11 (last on the third).
  - Required: identical words 1 cycle later, `o_last` on 2'b11, phase ignored.
- **Long stream:** 12 random dibits with puncturing enabled. Required output: exactly 8 words, bits matching the reference model order, phase wrapping every 3 dibits.
- **Reset mid-frame:** assert `i_reset` low after 2 dibits, then release it.
  - Required: outputs 0 immediately.
  - The next frame, 2'b01, 2'b10, 2'b00, reproduces the first test exactly, with phase restarting at 0.
- **Back-to-back frames with mode change:**
  - Frame A is punctured; frame B (`i_enable`=0) starts on the cycle right after A's last dibit.
  - Required: B's mode is latched correctly and no cross-frame bit mixing occurs.
